// File: rtl/binary_search3bit.sv
// ============================================================================
// Module   : binary_search3bit
// Brief    : Binary search of a hidden 3-bit target through an external
//            comparator; reports the match, or an error on inconsistent flags.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module binary_search3bit #(
    parameter int MAX_PROBES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       greater,
    input  logic       equal,
    input  logic       lower,
    output logic [2:0] probe,
    output logic       busy,
    output logic       done,
    output logic [2:0] result,
    output logic       found,
    output logic       err,
    output logic [2:0] probe_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_lo;
    logic [2:0] r_hi;

    logic       w_onehot;
    logic [2:0] w_cnt_next;
    logic       w_limit;
    logic [2:0] w_lo_up;
    logic [2:0] w_hi_dn;
    logic       w_fail;
    logic [2:0] w_next_lo;
    logic [2:0] w_next_hi;
    logic [2:0] w_next_probe;

    assign w_onehot   = ({greater, equal, lower} == 3'b100) ||
                        ({greater, equal, lower} == 3'b010) ||
                        ({greater, equal, lower} == 3'b001);
    assign w_cnt_next = (probe_count == 3'd7) ? 3'd7 : probe_count + 3'd1;
    assign w_limit    = (int'({29'd0, w_cnt_next}) >= MAX_PROBES);
    assign w_lo_up    = probe + 3'd1;
    assign w_hi_dn    = probe - 3'd1;

    // Midpoint sums are taken 4 bits wide so lo+hi never wraps.
    always_comb begin
        w_fail       = 1'b0;
        w_next_lo    = r_lo;
        w_next_hi    = r_hi;
        w_next_probe = probe;
        if (!w_onehot) begin
            w_fail = 1'b1;
        end else if (lower) begin
            w_next_lo    = w_lo_up;
            w_next_probe = 3'(({1'b0, w_lo_up} + {1'b0, r_hi}) >> 1);
            w_fail       = (probe == 3'd7) || (w_lo_up > r_hi) || w_limit;
        end else if (greater) begin
            w_next_hi    = w_hi_dn;
            w_next_probe = 3'(({1'b0, r_lo} + {1'b0, w_hi_dn}) >> 1);
            w_fail       = (probe == 3'd0) || (r_lo > w_hi_dn) || w_limit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            probe       <= 3'd0;
            result      <= 3'd0;
            probe_count <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            err         <= 1'b0;
            r_lo        <= 3'd0;
            r_hi        <= 3'd7;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state     <= SEARCH;
                        busy        <= 1'b1;
                        r_lo        <= 3'd0;
                        r_hi        <= 3'd7;
                        probe       <= 3'd3;
                        probe_count <= 3'd0;
                        found       <= 1'b0;
                        err         <= 1'b0;
                        result      <= 3'd0;
                    end
                end
                SEARCH: begin
                    probe_count <= w_cnt_next;
                    // A match takes priority over the probe-count limit.
                    if (w_onehot && equal) begin
                        result  <= probe;
                        found   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end else if (w_fail) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_lo  <= w_next_lo;
                        r_hi  <= w_next_hi;
                        probe <= w_next_probe;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_binary_search3bit.sv
// ============================================================================
// Module   : tb_binary_search3bit
// Brief    : Table-driven checks of binary_search3bit with a comparator model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_binary_search3bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       greater, equal, lower;
    logic [2:0] probe, result, probe_count;
    logic       busy, done, found, err;

    int         nvec = 0;
    int         nmis = 0;

    logic [2:0]  cur_target = 3'd0;
    logic [11:0] cur_script = 12'd0;
    int          sidx = 0;
    logic [2:0]  w_code;

    binary_search3bit #(.MAX_PROBES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .greater(greater), .equal(equal), .lower(lower),
        .probe(probe), .busy(busy), .done(done), .result(result),
        .found(found), .err(err), .probe_count(probe_count)
    );

    always #5 clk = ~clk;

    // Script code {g,e,l} per sample; zero selects the true comparator.
    always_comb begin
        w_code = cur_script[3*sidx +: 3];
        if (w_code != 3'd0)
            {greater, equal, lower} = w_code;
        else
            {greater, equal, lower} = {probe > cur_target, probe == cur_target, probe < cur_target};
    end

    typedef struct {
        logic [2:0]  target;
        logic [11:0] script;
        logic [11:0] seq;
        int          n;
        logic        found;
        logic        err;
        logic [2:0]  res;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " probe"}, int'(probe), 0);
        check({tag, " result"}, int'(result), 0);
        check({tag, " count"}, int'(probe_count), 0);
        check({tag, " flags"}, int'({busy, done, found, err}), 0);
    endtask

    task automatic run_search(input vec_t v, input string tag, input int restart_at);
        logic [11:0] got_seq;
        int k;
        int dcyc;
        got_seq    = 12'd0;
        k          = 0;
        dcyc       = 0;
        cur_target = v.target;
        cur_script = v.script;
        sidx       = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_start"}, int'(busy), 1);
        check({tag, " probe_first"}, int'(probe), 3);
        check({tag, " cnt_start"}, int'(probe_count), 0);
        check({tag, " cleared"}, int'({found, err, result}), 0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (busy && k < 4) begin
                got_seq[3*k +: 3] = probe;
                sidx = k;
                k++;
            end
            if (cyc == restart_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        check({tag, " done_latency"}, dcyc, v.n + 1);
        check({tag, " probe_seq"}, int'(got_seq), int'(v.seq));
        check({tag, " nprobes"}, k, v.n);
        check({tag, " found"}, int'(found), int'(v.found));
        check({tag, " err"}, int'(err), int'(v.err));
        check({tag, " result"}, int'(result), int'(v.res));
        check({tag, " count"}, int'(probe_count), v.n);
        check({tag, " probe_hold"}, int'(probe), int'(v.seq[3*(v.n-1) +: 3]));
        check({tag, " busy_end"}, int'(busy), 0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, int'(done), 0);
        check({tag, " found_held"}, int'(found), int'(v.found));
    endtask

    initial begin
        // Scripts: L=3'b001, G=3'b100, both=3'b101, all=3'b111.
        vecs[0]  = '{3'd3, 12'h000, {9'd0, 3'd3},                   1, 1'b1, 1'b0, 3'd3};
        vecs[1]  = '{3'd7, 12'h000, {3'd7, 3'd6, 3'd5, 3'd3},       4, 1'b1, 1'b0, 3'd7};
        vecs[2]  = '{3'd0, 12'h000, {3'd0, 3'd0, 3'd1, 3'd3},       3, 1'b1, 1'b0, 3'd0};
        vecs[3]  = '{3'd5, 12'h000, {6'd0, 3'd5, 3'd3},             2, 1'b1, 1'b0, 3'd5};
        vecs[4]  = '{3'd4, 12'h000, {3'd0, 3'd4, 3'd5, 3'd3},       3, 1'b1, 1'b0, 3'd4};
        vecs[5]  = '{3'd2, 12'h000, {3'd0, 3'd2, 3'd1, 3'd3},       3, 1'b1, 1'b0, 3'd2};
        vecs[6]  = '{3'd6, 12'h000, {3'd0, 3'd6, 3'd5, 3'd3},       3, 1'b1, 1'b0, 3'd6};
        vecs[7]  = '{3'd1, 12'h000, {6'd0, 3'd1, 3'd3},             2, 1'b1, 1'b0, 3'd1};
        vecs[8]  = '{3'd3, {9'd0, 3'b101}, {9'd0, 3'd3},            1, 1'b0, 1'b1, 3'd0};
        vecs[9]  = '{3'd0, {3'b001, 3'b001, 3'b001, 3'b001},
                     {3'd7, 3'd6, 3'd5, 3'd3},                      4, 1'b0, 1'b1, 3'd0};
        vecs[10] = '{3'd0, {3'd0, 3'b100, 3'b100, 3'b100},
                     {3'd0, 3'd0, 3'd1, 3'd3},                      3, 1'b0, 1'b1, 3'd0};
        vecs[11] = '{3'd0, {3'd0, 3'b100, 3'b100, 3'b001},
                     {3'd0, 3'd4, 3'd5, 3'd3},                      3, 1'b0, 1'b1, 3'd0};
        vecs[12] = '{3'd3, {9'd0, 3'b111}, {9'd0, 3'd3},            1, 1'b0, 1'b1, 3'd0};

        #1;
        check_idle_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_search(vecs[i], $sformatf("v%0d", i), 0);

        // Start pulsed mid-search must not disturb the in-flight search.
        run_search(vecs[1], "busy_start", 2);

        // Asynchronous reset after the second probe aborts without done.
        cur_target = 3'd7;
        cur_script = 12'd0;
        sidx = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle_zero("async_rst");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_no_done", int'(done), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_search(vecs[3], "after_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/binary_search3bit.md
BINARY_SEARCH3BIT -- requirements
Module: binary_search3bit

Interface
REQ-001 Parameter MAX_PROBES, default 4, is the maximum number of probes per search before the error abort.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 probe  output  3  registered candidate value, driven to the external 3-bit comparator's "a" operand.
REQ-006 greater, equal, lower  input  1 each  comparator flags for probe vs. hidden target: probe>target, probe==target, probe<target.
REQ-007 busy  output  1  high in SEARCH.
REQ-008 done  output  1  one-cycle pulse when a search ends (found or error).
REQ-009 result  output  3  matched value; valid while found=1.
REQ-010 found  output  1  last search matched; held until the next start.
REQ-011 err  output  1  last search aborted; held until the next start.
REQ-012 probe_count  output  3  probes consumed by the last/current search.

Function
REQ-013 The block SHALL have exactly three states: IDLE, SEARCH and DONE.
REQ-014 IDLE with start=1: go to SEARCH; lo=0, hi=7, probe=3, probe_count=0; clear found, err and result.
REQ-015 IDLE with start=0: hold all outputs.
REQ-016 In SEARCH, each edge samples the flags for the current probe and increments probe_count (saturating at 7).
REQ-017 equal alone: result=probe, found=1, go to DONE.
REQ-018 lower alone: lo=probe+1; probe=(lo_new+hi)>>1.
REQ-019 greater alone: hi=probe-1; probe=(lo+hi_new)>>1.
REQ-020 lo+hi SHALL be computed 4 bits wide, with no overflow.
REQ-021 Any of the following SHALL set err=1 and go to DONE; result and probe hold; found stays 0:
- flags not exactly one-hot;
- lower with probe=7;
- greater with probe=0;
- resulting lo>hi;
- probe_count reaching MAX_PROBES without equal.
REQ-022 If equal and the probe-count limit coincide, equal SHALL win (found=1, err=0).
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 start in SEARCH or DONE SHALL be ignored and not queued.
REQ-025 busy=1 exactly in SEARCH; probe SHALL hold its last value outside SEARCH.
REQ-026 Latency: with start sampled at edge 0 and a target reached on the n-th probe, done is high in the cycle after edge n+1; worst case n=4.

Reset
REQ-027 rst=1 SHALL immediately set:
- state=IDLE;
- probe=0, result=0, probe_count=0;
- busy=0, done=0, found=0, err=0;
- lo=0, hi=7.
REQ-028 Reset asserted mid-search SHALL abort the search without emitting done.
REQ-029 The first start after reset deassertion SHALL be honoured.

Verification
REQ-030 Bench: target 3, start pulse -> probe 3, equal at the first sample; done, found=1, result=3, probe_count=1.
REQ-031 Bench: target 7 -> probe sequence 3,5,6,7; found=1, result=7, probe_count=4; done one cycle only.
REQ-032 Bench: target 0 -> probe sequence 3,1,0; found=1, result=0, probe_count=3.
REQ-033 Bench: comparator forced to greater=1 and lower=1 -> err=1, found=0, done pulse after the first sample.
REQ-034 Bench: start pulsed while busy -> ignored; the in-flight search completes normally with the same probe sequence.
REQ-035 Bench: rst asserted after the second probe -> all outputs 0 asynchronously, no done pulse; a new start finds target 5 via 3,5.
